prog_ram_loader: RTL

- Writable 16-entry program store that replaces the fixed 16-byte ROM, plus the writer side that fills it.
- Byte stream enters over a valid/ready handshake: 16 instruction bytes followed by one checksum byte.
- CPU side keeps the ROM read interface: ADDRESS in, OP_CODE and ROM_DATA out.
- CPU_HOLD stalls the program counter while a load is in progress or has failed.

---
 rtl/prog_ram_loader.sv | 127 ++++++++++++
 1 files changed

// File: rtl/prog_ram_loader.sv
// prog_ram_loader: writable 2**ADDR_W-entry program store with a byte-stream loader.
//
// A load is started by LOAD_START. It then accepts DEPTH program bytes over a
// valid/ready handshake, followed by one checksum byte when CHECKSUM_EN is set.
// The CPU keeps a combinational ROM-style read port on the same storage.
//
// Ports:
//   CLK, RESET_N       clock (rising edge) and synchronous active-low reset
//   LOAD_START         single-cycle load request (ignored while a load is running)
//   IN_DATA, IN_VALID  incoming byte and its valid flag
//   IN_READY           loader accepts a byte this cycle
//   ADDRESS            CPU fetch address
//   OP_CODE, ROM_DATA  upper and lower halves of mem[ADDRESS]
//   CPU_HOLD           stall the program counter (load running or failed)
//   LOAD_DONE          last load completed and verified
//   LOAD_ERR           last load failed its checksum
//   WR_PTR             next write address (debug)
module prog_ram_loader #(
   parameter int unsigned ADDR_W      = 4,
   parameter int unsigned DATA_W      = 8,
   parameter bit          CHECKSUM_EN = 1'b1
) (
   input  logic                CLK,
   input  logic                RESET_N,
   input  logic                LOAD_START,
   input  logic [DATA_W-1:0]   IN_DATA,
   input  logic                IN_VALID,
   output logic                IN_READY,
   input  logic [ADDR_W-1:0]   ADDRESS,
   output logic [DATA_W/2-1:0] OP_CODE,
   output logic [DATA_W/2-1:0] ROM_DATA,
   output logic                CPU_HOLD,
   output logic                LOAD_DONE,
   output logic                LOAD_ERR,
   output logic [ADDR_W-1:0]   WR_PTR
);

   localparam int unsigned Depth = 2 ** ADDR_W;
   localparam int unsigned HalfW = DATA_W / 2;

   typedef enum logic [2:0] {StIdle, StLoad, StCheck, StDone, StErr} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [DATA_W-1:0]   sum_q, sum_d;
   logic [DATA_W-1:0]   mem_q [Depth];
   logic [DATA_W-1:0]   mem_d [Depth];
   logic                in_ready_q, in_ready_d;
   logic                hold_q, hold_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic                xfer;

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      sum_d    = sum_q;
      mem_d    = mem_q;
      // in_ready_q mirrors the current state, so a byte offered alongside
      // LOAD_START in IDLE is never taken.
      xfer     = IN_VALID & in_ready_q;

      unique case (state_q)
         StIdle, StDone, StErr: begin
            if (LOAD_START) begin
               state_d  = StLoad;
               wr_ptr_d = '0;
               sum_d    = '0;
            end
         end
         StLoad: begin
            if (xfer) begin
               mem_d[wr_ptr_q] = IN_DATA;
               sum_d           = sum_q + IN_DATA;
               wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
               if (&wr_ptr_q) begin
                  state_d = CHECKSUM_EN ? StCheck : StDone;
               end
            end
         end
         StCheck: begin
            // The checksum byte is compared only, never stored.
            if (xfer) begin
               state_d = (IN_DATA == sum_q) ? StDone : StErr;
            end
         end
         default: state_d = StIdle;
      endcase

      // Status flags are registered from the next state.
      in_ready_d = (state_d == StLoad) || (state_d == StCheck);
      hold_d     = (state_d == StLoad) || (state_d == StCheck) || (state_d == StErr);
      done_d     = (state_d == StDone);
      err_d      = (state_d == StErr);
   end

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state_q    <= StIdle;
         wr_ptr_q   <= '0;
         sum_q      <= '0;
         mem_q      <= '{default: '0};
         in_ready_q <= 1'b0;
         hold_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         sum_q      <= sum_d;
         mem_q      <= mem_d;
         in_ready_q <= in_ready_d;
         hold_q     <= hold_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign OP_CODE   = mem_q[ADDRESS][DATA_W-1 -: HalfW];
   assign ROM_DATA  = mem_q[ADDRESS][HalfW-1:0];
   assign IN_READY  = in_ready_q;
   assign CPU_HOLD  = hold_q;
   assign LOAD_DONE = done_q;
   assign LOAD_ERR  = err_q;
   assign WR_PTR    = wr_ptr_q;

endmodule
